ecc_fp_inv_seq: RTL and testbench
=================================

Name: ecc_fp_inv_seq

Overview:
- Field-inversion sequencer sitting directly upstream of ECC_core; computes R = A^(P-2) mod P (Fermat inversion) by left-to-right square-and-multiply.
- Each square/multiply is issued to ECC_core as one MUL command (alu_sel = 3'b011) over ECC_core's start/done handshake.
- Serves the point-arithmetic layer, which needs one inversion per affine conversion; default P = 2^255-19.

Parameters:
- WIDTH, 256, operand/prime width in bits
- ALU_MUL, 3'b011, alu_sel code for modular multiply in ECC_core

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle request pulse; sampled only in IDLE
- operand  in  WIDTH  A, value to invert; sampled with start
- prime  in  WIDTH  P, odd modulus; sampled with start
- result  out  WIDTH  A^(P-2) mod P; valid when done=1, held until next accepted start
- done  out  1  1-cycle completion pulse
- busy  out  1  high from accepted start until done cycle inclusive
- err  out  1  valid with done: 1 = invalid input (A==0, A>=P, or P<3), result=0
- core_start  out  1  to ECC_core.start
- core_a  out  WIDTH  to ECC_core.a
- core_b  out  WIDTH  to ECC_core.b
- core_prime  out  WIDTH  to ECC_core.prime (latched P)
- core_alu_sel  out  3  to ECC_core.alu_sel, constant ALU_MUL while core_start=1
- core_result  in  WIDTH  from ECC_core.alu_result
- core_done  in  1  from ECC_core.done

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; result=0, done=0, busy=0, err=0, core_start=0, core_a=0, core_b=0, core_prime=0, core_alu_sel=0. Reset mid-operation abandons the inversion and drops core_start the same instant.
- Registers: A, P, E=P-2 (WIDTH-bit subtract at capture), R accumulator, bit index idx (log2 WIDTH bits), pending-mul flag.
- States: IDLE, CHECK, SCAN, SQR, MUL, RELEASE, FINISH.
- IDLE: on start=1 latch operand/prime, busy=1, go to CHECK. start while busy is ignored.
- CHECK (1 cycle): if A==0 or A>=P or P<3, go to FINISH with err=1 and R=0. Else set R=A, idx=WIDTH-1, and go to SCAN.
- SCAN: one bit per cycle, decrementing idx until E[idx]==1 (MSB found). Then if idx==0, go to FINISH (R=A). Else idx=idx-1 and go to SQR.
- SQR: core_a=R, core_b=R, core_alu_sel=ALU_MUL, core_start=1, held stable until core_done=1 sampled. On that edge: R<=core_result, core_start<=0, pending-mul=E[idx], go to RELEASE.
- MUL: same as SQR with core_a=R, core_b=A. On core_done: R<=core_result, pending-mul=0, go to RELEASE.
- RELEASE: core_start=0 until core_done==0 (minimum 1 cycle), then pick next step:
  - pending-mul=1: go to MUL.
  - idx==0: go to FINISH.
  - otherwise: idx=idx-1, go to SQR.
- FINISH (1 cycle): result<=R, done=1, err as determined, busy=0 on the next cycle, then IDLE.
- Core operand buses are don't-care but must be stable whenever core_start=1. No combinational path from core_* inputs to core_* outputs.
- Command count: (msb_index of E) squarings + (popcount(E)-1) multiplies.

Test Plan:
- P=13, A=3 (E=11=1011b) -> exactly 5 core commands (SQR, SQR, MUL, SQR, MUL); result=9, err=0, done one pulse.
- P=2^255-19, A=2 -> result=0x3fff...fff7 (i.e. (P+1)/2); 254 SQR + 252 MUL = 506 core_start rising edges.
- P=2^255-19, A=1 -> result=1; A=P-1 -> result=P-1.
- A=0, and separately A=P -> done within 3 cycles of start, err=1, result=0, core_start never asserted.
- Assert i_rst_n=0 during the 100th core command -> core_start/busy/done drop immediately. A new start after release gives the correct inverse for a fresh A (P=13, A=5 -> 8).
- Second start pulse while busy -> ignored: only one done, result from the first operands. core_done held high for 4 cycles by a stub core -> no duplicate command issued until core_done falls.

Source files
------------

// File: rtl/ecc_fp_inv_seq_if.sv
// Bus bundle for the Fermat inversion sequencer: request/response side plus
// the MUL command handshake toward ECC_core.
interface ecc_fp_inv_seq_if #(
   parameter int WIDTH = 256
);
   logic             start;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] prime;
   logic [WIDTH-1:0] result;
   logic             done;
   logic             busy;
   logic             err;
   logic             core_start;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_prime;
   logic [2:0]       core_alu_sel;
   logic [WIDTH-1:0] core_result;
   logic             core_done;

   // master = requester and ECC_core side, slave = the sequencer itself
   modport master (
      output start, operand, prime, core_result, core_done,
      input  result, done, busy, err,
             core_start, core_a, core_b, core_prime, core_alu_sel
   );

   modport slave (
      input  start, operand, prime, core_result, core_done,
      output result, done, busy, err,
             core_start, core_a, core_b, core_prime, core_alu_sel
   );
endinterface

// File: rtl/ecc_fp_inv_seq.sv
// Field inversion R = A^(P-2) mod P by left-to-right square-and-multiply,
// issuing every square/multiply to ECC_core as one MUL command.
module ecc_fp_inv_seq #(
   parameter int         WIDTH   = 256,
   parameter logic [2:0] ALU_MUL = 3'b011
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   ecc_fp_inv_seq_if.slave bus
);
   localparam int               IDX_W   = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SCAN,
      SQR,
      MUL,
      RELEASE,
      FINISH
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] modulus;
   logic [WIDTH-1:0] expo;
   logic [WIDTH-1:0] acc;
   logic [IDX_W-1:0] idx;
   logic             pend_mul;

   logic [WIDTH-1:0] res_hold;
   logic             done_pulse;
   logic             busy_flag;
   logic             err_flag;
   logic             cmd_start;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [WIDTH-1:0] cmd_prime;
   logic [2:0]       cmd_sel;

   logic             invalid;
   logic             idx_zero;

   // Zero has no inverse; A >= P is not a reduced field element; P < 3 leaves no usable exponent.
   assign invalid  = (base == '0) || (base >= modulus) || (modulus < WIDTH'(3));
   assign idx_zero = (idx == '0);

   assign bus.result       = res_hold;
   assign bus.done         = done_pulse;
   assign bus.busy         = busy_flag;
   assign bus.err          = err_flag;
   assign bus.core_start   = cmd_start;
   assign bus.core_a       = cmd_a;
   assign bus.core_b       = cmd_b;
   assign bus.core_prime   = cmd_prime;
   assign bus.core_alu_sel = cmd_sel;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CHECK;
         CHECK:   state_nxt = invalid ? FINISH : SCAN;
         SCAN: begin
            if (expo[idx]) state_nxt = idx_zero ? FINISH : SQR;
         end
         SQR:     if (bus.core_done) state_nxt = RELEASE;
         MUL:     if (bus.core_done) state_nxt = RELEASE;
         RELEASE: begin
            // Wait for the core to drop done so one command never spans two requests.
            if (!bus.core_done) begin
               if (pend_mul)      state_nxt = MUL;
               else if (idx_zero) state_nxt = FINISH;
               else               state_nxt = SQR;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         base       <= '0;
         modulus    <= '0;
         expo       <= '0;
         acc        <= '0;
         idx        <= '0;
         pend_mul   <= 1'b0;
         res_hold   <= '0;
         done_pulse <= 1'b0;
         busy_flag  <= 1'b0;
         err_flag   <= 1'b0;
         cmd_start  <= 1'b0;
         cmd_a      <= '0;
         cmd_b      <= '0;
         cmd_prime  <= '0;
         cmd_sel    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  base      <= bus.operand;
                  modulus   <= bus.prime;
                  expo      <= bus.prime - WIDTH'(2);
                  cmd_prime <= bus.prime;
                  busy_flag <= 1'b1;
               end
            end
            CHECK: begin
               if (invalid) begin
                  acc        <= '0;
                  res_hold   <= '0;
                  err_flag   <= 1'b1;
                  done_pulse <= 1'b1;
               end else begin
                  acc <= base;
                  idx <= IDX_TOP;
               end
            end
            SCAN: begin
               if (expo[idx]) begin
                  if (idx_zero) begin
                     res_hold   <= acc;
                     err_flag   <= 1'b0;
                     done_pulse <= 1'b1;
                  end else begin
                     idx       <= idx - 1'b1;
                     cmd_start <= 1'b1;
                     cmd_a     <= acc;
                     cmd_b     <= acc;
                     cmd_sel   <= ALU_MUL;
                  end
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            SQR: begin
               if (bus.core_done) begin
                  acc       <= bus.core_result;
                  cmd_start <= 1'b0;
                  pend_mul  <= expo[idx];
               end
            end
            MUL: begin
               if (bus.core_done) begin
                  acc       <= bus.core_result;
                  cmd_start <= 1'b0;
                  pend_mul  <= 1'b0;
               end
            end
            RELEASE: begin
               if (!bus.core_done) begin
                  if (pend_mul) begin
                     cmd_start <= 1'b1;
                     cmd_a     <= acc;
                     cmd_b     <= base;
                     cmd_sel   <= ALU_MUL;
                  end else if (idx_zero) begin
                     res_hold   <= acc;
                     err_flag   <= 1'b0;
                     done_pulse <= 1'b1;
                  end else begin
                     idx       <= idx - 1'b1;
                     cmd_start <= 1'b1;
                     cmd_a     <= acc;
                     cmd_b     <= acc;
                     cmd_sel   <= ALU_MUL;
                  end
               end
            end
            FINISH: begin
               done_pulse <= 1'b0;
               busy_flag  <= 1'b0;
            end
            default: begin
               cmd_start <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ecc_fp_inv_seq.sv
// Bench for ecc_fp_inv_seq: a stub ECC_core answers MUL commands with a*b mod p,
// results are compared with a right-to-left modular exponentiation model.
module tb_ecc_fp_inv_seq;
   localparam int         W       = 256;
   localparam logic [2:0] ALU_MUL = 3'b011;
   localparam logic [W-1:0] P25519 = (W'(1) << 255) - W'(19);

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ecc_fp_inv_seq_if #(.WIDTH(W)) bus ();

   ecc_fp_inv_seq #(.WIDTH(W), .ALU_MUL(ALU_MUL)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference arithmetic ----------------
   function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] p);
      logic [2*W-1:0] t;
      t = (2*W)'(x) * (2*W)'(y);
      t = t % (2*W)'(p);
      return t[W-1:0];
   endfunction

   function automatic bit ref_err(input logic [W-1:0] a, input logic [W-1:0] p);
      return (a == '0) || (a >= p) || (p < W'(3));
   endfunction

   function automatic logic [W-1:0] ref_inv(input logic [W-1:0] a, input logic [W-1:0] p);
      logic [W-1:0] r, b, e;
      if (ref_err(a, p)) return '0;
      e = p - W'(2);
      r = W'(1);
      b = a;
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = mulmod(r, b, p);
         b = mulmod(b, b, p);
      end
      return r;
   endfunction

   function automatic int ref_cmds(input logic [W-1:0] p);
      logic [W-1:0] e;
      int msb;
      e = p - W'(2);
      msb = 0;
      for (int i = 0; i < W; i++) if (e[i]) msb = i;
      return msb + $countones(e) - 1;
   endfunction

   // ---------------- stub ECC_core ----------------
   int unsigned  phase, lat_left, hold_left, hold_cfg;
   bit           seen_done;
   logic         cs_q;
   logic [W-1:0] lat_a, lat_b, exp_prime;
   int           rise_cnt, cmd_cnt, dup_err, stab_err, done_cnt;
   logic [W-1:0] log_a[$];
   logic [W-1:0] log_b[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         phase     = 0;
         cs_q      = 1'b0;
         seen_done = 1'b0;
         bus.core_done   <= 1'b0;
         bus.core_result <= '0;
      end else begin
         if (bus.core_start && !cs_q) rise_cnt++;
         cs_q = bus.core_start;
         if (bus.done) done_cnt++;
         case (phase)
            0: begin
               if (bus.core_start) begin
                  cmd_cnt++;
                  lat_a = bus.core_a;
                  lat_b = bus.core_b;
                  log_a.push_back(bus.core_a);
                  log_b.push_back(bus.core_b);
                  if (bus.core_alu_sel !== ALU_MUL || bus.core_prime !== exp_prime) stab_err++;
                  bus.core_result <= mulmod(bus.core_a, bus.core_b, bus.core_prime);
                  lat_left = $urandom_range(2, 0);
                  phase = 1;
               end
            end
            1: begin
               if (bus.core_start !== 1'b1 || bus.core_a !== lat_a || bus.core_b !== lat_b) stab_err++;
               if (lat_left == 0) begin
                  bus.core_done <= 1'b1;
                  hold_left = hold_cfg;
                  seen_done = 1'b0;
                  phase = 2;
               end else begin
                  lat_left--;
               end
            end
            default: begin
               if (seen_done && bus.core_start) dup_err++;
               else if (!seen_done && (bus.core_a !== lat_a || bus.core_b !== lat_b)) stab_err++;
               seen_done = 1'b1;
               if (hold_left <= 1) begin
                  bus.core_done <= 1'b0;
                  phase = 0;
               end else begin
                  hold_left--;
               end
            end
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_counters(input logic [W-1:0] p);
      rise_cnt = 0; cmd_cnt = 0; dup_err = 0; stab_err = 0; done_cnt = 0;
      log_a.delete(); log_b.delete();
      exp_prime = p;
   endtask

   task automatic do_inv(input logic [W-1:0] a, input logic [W-1:0] p,
                         output logic [W-1:0] res, output logic e, output int lat, output bit to);
      int n;
      clear_counters(p);
      @(posedge clk); #1;
      bus.operand = a;
      bus.prime   = p;
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 1;
      while (bus.done !== 1'b1 && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      to  = (bus.done !== 1'b1);
      res = bus.result;
      e   = bus.err;
      lat = n;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.result !== '0)      begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
      checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
      checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", bus.core_start); end
      checks++; if (bus.core_a !== '0 || bus.core_b !== '0 || bus.core_prime !== '0)
                   begin errors++; $display("FAIL reset_core_ops: got a=%h b=%h p=%h want 0", bus.core_a, bus.core_b, bus.core_prime); end
      checks++; if (bus.core_alu_sel !== 3'b000) begin errors++; $display("FAIL reset_alu_sel: got %b want 000", bus.core_alu_sel); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
                   begin errors++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
   endtask

   task automatic test_small();
      logic [W-1:0] res;
      logic         e;
      int           lat, bad;
      bit           to;
      logic [W-1:0] exp_a [5];
      logic [W-1:0] exp_b [5];
      exp_a = '{W'(3), W'(9), W'(3), W'(9), W'(3)};
      exp_b = '{W'(3), W'(9), W'(3), W'(9), W'(3)};
      do_inv(W'(3), W'(13), res, e, lat, to);
      checks++; if (to) begin errors++; $display("FAIL small_timeout: no done after %0d cycles", lat); end
      checks++; if (res !== W'(9) || res !== ref_inv(W'(3), W'(13)))
                   begin errors++; $display("FAIL small_result: got %0d want 9", res); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL small_err: got %b want 0", e); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL small_done_pulses: got %0d want 1", done_cnt); end
      checks++; if (cmd_cnt != 5 || rise_cnt != 5)
                   begin errors++; $display("FAIL small_cmds: got %0d cmds %0d rises want 5", cmd_cnt, rise_cnt); end
      bad = 0;
      for (int i = 0; i < 5; i++)
         if (i >= log_a.size() || log_a[i] !== exp_a[i] || log_b[i] !== exp_b[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL small_cmd_operands: %0d of 5 commands carried wrong operands", bad); end
      checks++; if (stab_err != 0 || dup_err != 0)
                   begin errors++; $display("FAIL small_handshake: got stab=%0d dup=%0d want 0 0", stab_err, dup_err); end
   endtask

   task automatic test_invalid();
      logic [W-1:0] ta [4];
      logic [W-1:0] tp [4];
      logic [W-1:0] res;
      logic         e;
      int           lat;
      bit           to;
      ta = '{W'(0), P25519, W'(5), W'(20)};
      tp = '{P25519, P25519, W'(2), W'(13)};
      for (int k = 0; k < 4; k++) begin
         do_inv(ta[k], tp[k], res, e, lat, to);
         checks++; if (to || lat > 3)
                      begin errors++; $display("FAIL invalid_latency[%0d]: got %0d cycles want <=3", k, lat); end
         checks++; if (e !== 1'b1 || res !== '0)
                      begin errors++; $display("FAIL invalid_flag[%0d]: got err=%b res=%h want 1 0", k, e, res); end
         checks++; if (rise_cnt != 0 || done_cnt != 1)
                      begin errors++; $display("FAIL invalid_cmds[%0d]: got %0d cmds %0d dones want 0 1", k, rise_cnt, done_cnt); end
      end
   endtask

   task automatic test_default_prime();
      logic [W-1:0] ta [3];
      logic [W-1:0] tw [3];
      logic [W-1:0] res;
      logic         e;
      int           lat;
      bit           to;
      ta = '{W'(2), W'(1), P25519 - W'(1)};
      tw = '{(P25519 + W'(1)) >> 1, W'(1), P25519 - W'(1)};
      for (int k = 0; k < 3; k++) begin
         do_inv(ta[k], P25519, res, e, lat, to);
         checks++; if (to || e !== 1'b0)
                      begin errors++; $display("FAIL p25519_done[%0d]: timeout=%0d err=%b want 0 0", k, to, e); end
         checks++; if (res !== tw[k] || res !== ref_inv(ta[k], P25519))
                      begin errors++; $display("FAIL p25519_result[%0d]: got %h want %h", k, res, tw[k]); end
         checks++; if (rise_cnt != ref_cmds(P25519) || rise_cnt != 506 || cmd_cnt != 506)
                      begin errors++; $display("FAIL p25519_cmds[%0d]: got %0d rises %0d cmds want 506", k, rise_cnt, cmd_cnt); end
         checks++; if (stab_err != 0 || dup_err != 0 || done_cnt != 1)
                      begin errors++; $display("FAIL p25519_handshake[%0d]: stab=%0d dup=%0d dones=%0d want 0 0 1", k, stab_err, dup_err, done_cnt); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] primes [7];
      logic [W-1:0] a, p, res, w;
      logic         e;
      int           lat;
      bit           to;
      primes = '{W'(13), W'(17), W'(101), W'(257), W'(65537), W'(32'd2147483647), W'(32'd4294967291)};
      for (int k = 0; k < 8; k++) begin
         if (k < 6) begin
            p = primes[$urandom_range(6, 0)];
            a = W'($urandom) % p;
         end else begin
            p = P25519;
            a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            a = a % p;
         end
         w = ref_inv(a, p);
         do_inv(a, p, res, e, lat, to);
         checks++; if (to || res !== w || e !== ref_err(a, p))
                      begin errors++; $display("FAIL random_result[%0d]: a=%h p=%h got %h err=%b want %h", k, a, p, res, e, w); end
         if (!ref_err(a, p)) begin
            checks++; if (mulmod(res, a, p) !== W'(1))
                         begin errors++; $display("FAIL random_inverse[%0d]: a*r mod p got %h want 1", k, mulmod(res, a, p)); end
            checks++; if (rise_cnt != ref_cmds(p) || stab_err != 0 || dup_err != 0)
                         begin errors++; $display("FAIL random_cmds[%0d]: got %0d want %0d (stab=%0d dup=%0d)", k, rise_cnt, ref_cmds(p), stab_err, dup_err); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] res;
      logic         e;
      int           lat, n;
      bit           to;
      clear_counters(P25519);
      @(posedge clk); #1;
      bus.operand = W'(7);
      bus.prime   = P25519;
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (rise_cnt < 100 && n < 10000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (rise_cnt < 100) begin errors++; $display("FAIL midreset_reach: got %0d commands want 100", rise_cnt); end
      checks++; if (bus.core_start !== 1'b1 || bus.busy !== 1'b1)
                   begin errors++; $display("FAIL midreset_active: got start=%b busy=%b want 1 1", bus.core_start, bus.busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.core_start !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
                   begin errors++; $display("FAIL midreset_drop: got start=%b busy=%b done=%b want 0 0 0", bus.core_start, bus.busy, bus.done); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_inv(W'(5), W'(13), res, e, lat, to);
      checks++; if (to || res !== W'(8) || e !== 1'b0)
                   begin errors++; $display("FAIL midreset_fresh: got %0d err=%b want 8 0", res, e); end
   endtask

   task automatic test_back_to_back();
      int n;
      hold_cfg = 4;
      clear_counters(W'(13));
      @(posedge clk); #1;
      bus.operand = W'(3);
      bus.prime   = W'(13);
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.operand = W'(5);
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (bus.done !== 1'b1 || bus.result !== W'(9))
                   begin errors++; $display("FAIL b2b_result: got done=%b res=%0d want 1 9", bus.done, bus.result); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (done_cnt != 1 || bus.busy !== 1'b0)
                   begin errors++; $display("FAIL b2b_single_done: got %0d dones busy=%b want 1 0", done_cnt, bus.busy); end
      checks++; if (cmd_cnt != 5 || rise_cnt != 5 || dup_err != 0 || stab_err != 0)
                   begin errors++; $display("FAIL b2b_cmds: got cmds=%0d rises=%0d dup=%0d stab=%0d want 5 5 0 0", cmd_cnt, rise_cnt, dup_err, stab_err); end
      hold_cfg = 1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      checks      = 0;
      errors      = 0;
      hold_cfg    = 1;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.operand = '0;
      bus.prime   = '0;
      exp_prime   = '0;
      test_reset();
      test_small();
      test_invalid();
      test_default_prime();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
